// File: rtl/drive_status_display_if.sv
// Signal bundle between the drive controller side and the status/display block.
interface drive_status_display_if;
    logic [3:0]  state;
    logic [3:0]  move_cmd;
    logic        clr_odo;
    logic        led_left;
    logic        led_right;
    logic [15:0] odo_bcd;
    logic [3:0]  seg_en;
    logic [6:0]  seg_out;

    modport master (
        output state, move_cmd, clr_odo,
        input  led_left, led_right, odo_bcd, seg_en, seg_out
    );

    modport slave (
        input  state, move_cmd, clr_odo,
        output led_left, led_right, odo_bcd, seg_en, seg_out
    );
endinterface

// File: rtl/drive_status_display.sv
// Drive status display: BCD odometer, blinking turn LEDs and a 4-digit
// multiplexed 7-segment readout of the odometer.
module drive_status_display #(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned BLINK_DIV = 50_000_000,
    parameter int unsigned SCAN_DIV  = 100_000
) (
    input logic                   clk,
    input logic                   rst,
    drive_status_display_if.slave bus
);

    localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [TickW-1:0]  TickLast  = TickW'(TICK_DIV - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);
    localparam logic [ScanW-1:0]  ScanLast  = ScanW'(SCAN_DIV - 1);

    localparam logic [3:0] StMoving   = 4'b0100;
    localparam logic [3:0] StPowerOff = 4'b1000;
    localparam logic [6:0] SegZero    = 7'b0111111;

    logic [TickW-1:0]  tick_q, tick_d;
    logic [15:0]       odo_q, odo_d;
    logic [BlinkW-1:0] blink_q, blink_d;
    logic              phase_q, phase_d;
    logic              any_q, any_d;
    logic              led_l_q, led_l_d;
    logic              led_r_q, led_r_d;
    logic [ScanW-1:0]  scan_q, scan_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        seg_en_q, seg_en_d;
    logic [6:0]        seg_out_q, seg_out_d;

    logic       moving, power_off, req_l, req_r, any_req;
    logic [3:0] digit;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Non-one-hot state codes match neither compare, so they act as unstarting.
    assign moving    = (bus.state == StMoving) && (bus.move_cmd[0] || bus.move_cmd[1]);
    assign power_off = (bus.state == StPowerOff);
    assign req_l     = bus.move_cmd[2];
    assign req_r     = bus.move_cmd[3];
    assign any_req   = req_l | req_r;

    always_comb begin
        tick_d = tick_q;
        odo_d  = odo_q;
        if (bus.clr_odo) begin
            tick_d = '0;
            odo_d  = '0;
        end else if (moving) begin
            if (tick_q == TickLast) begin
                tick_d = '0;
                odo_d  = bcd_inc(odo_q);
            end else begin
                tick_d = tick_q + TickW'(1);
            end
        end else begin
            tick_d = '0;
        end
    end

    always_comb begin
        blink_d = blink_q;
        phase_d = phase_q;
        any_d   = any_req;
        if (power_off) begin
            blink_d = '0;
            phase_d = 1'b0;
            any_d   = 1'b0;
        end else if (any_req && !any_q) begin
            blink_d = '0;
            phase_d = 1'b1;
        end else if (any_req) begin
            if (blink_q == BlinkLast) begin
                blink_d = '0;
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + BlinkW'(1);
            end
        end else begin
            blink_d = '0;
            phase_d = 1'b0;
        end
        led_l_d = req_l & phase_d;
        led_r_d = req_r & phase_d;
    end

    always_comb begin
        scan_d = scan_q + ScanW'(1);
        idx_d  = idx_q;
        if (scan_q == ScanLast) begin
            scan_d = '0;
            idx_d  = idx_q + 2'd1;
        end
        // Decode from the next odometer value so the readout never lags odo_bcd.
        digit = odo_d[{idx_d, 2'b00} +: 4];
        if (power_off) begin
            seg_en_d  = 4'b0000;
            seg_out_d = 7'b0000000;
        end else begin
            seg_en_d  = 4'b0001 << idx_d;
            seg_out_d = seg_decode(digit);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q    <= '0;
            odo_q     <= '0;
            blink_q   <= '0;
            phase_q   <= 1'b0;
            any_q     <= 1'b0;
            led_l_q   <= 1'b0;
            led_r_q   <= 1'b0;
            scan_q    <= '0;
            idx_q     <= 2'd0;
            seg_en_q  <= 4'b0001;
            seg_out_q <= SegZero;
        end else begin
            tick_q    <= tick_d;
            odo_q     <= odo_d;
            blink_q   <= blink_d;
            phase_q   <= phase_d;
            any_q     <= any_d;
            led_l_q   <= led_l_d;
            led_r_q   <= led_r_d;
            scan_q    <= scan_d;
            idx_q     <= idx_d;
            seg_en_q  <= seg_en_d;
            seg_out_q <= seg_out_d;
        end
    end

    assign bus.odo_bcd   = odo_q;
    assign bus.led_left  = led_l_q;
    assign bus.led_right = led_r_q;
    assign bus.seg_en    = seg_en_q;
    assign bus.seg_out   = seg_out_q;

endmodule

// File: doc/drive_status_display.md
Name: drive_status_display

Overview:
- Downstream consumer of the manual-driving controller's outputs: the one-hot drive state and the 4-bit motion command.
- Accumulates mileage as a 4-digit BCD odometer while the car is moving.
- Drives blinking left/right turn-signal LEDs.
- Time-multiplexes the odometer onto a 4-digit common-enable 7-segment display (EGO1 board, 100 MHz clock).

Parameters:
- TICK_DIV, 100_000_000, clk cycles of forward/reverse motion per one mileage unit.
- BLINK_DIV, 50_000_000, clk cycles per turn-LED half period (1 Hz blink).
- SCAN_DIV, 100_000, clk cycles each display digit stays enabled.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- state  in  4  one-hot drive state: 0001 unstarting, 0010 starting, 0100 moving, 1000 power_off.
- move_cmd  in  4  {right, left, back, forward} motion/turn request bits.
- clr_odo  in  1  synchronous odometer clear, level-sensitive.
- led_left  out  1  left turn LED, 1 = lit.
- led_right  out  1  right turn LED, 1 = lit.
- odo_bcd  out  16  odometer, 4 BCD digits, [3:0] = ones.
- seg_en  out  4  digit enables, one-hot, 1 = enabled, bit0 = ones digit.
- seg_out  out  7  segments {g,f,e,d,c,b,a}, 1 = lit.

Behaviour:
- Reset is asynchronous, entered on rst low, and applies while rst is low. Reset values:
  - odo_bcd = 0, all internal counters = 0, blink phase = 0.
  - led_left = led_right = 0.
  - seg_en = 0001, seg_out = 0111111 (digit "0").
- All outputs are registered. Illegal (non-one-hot) state values are treated as unstarting.
- Odometer:
  - The moving condition is state == 0100 and (move_cmd[0] or move_cmd[1]).
  - While the moving condition holds, the prescaler counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and odo_bcd increments by 1 in BCD on the same edge.
  - Forward and reverse both count.
  - When the moving condition is false, the prescaler resets to 0. Partial units are discarded.
  - BCD carry ripples per digit (9 -> 0 with carry). 9999 wraps to 0000.
  - clr_odo = 1 clears odo_bcd and the prescaler on that edge. clr_odo has priority over a coincident increment.
  - power_off holds odo_bcd; it is not cleared.
- Turn signals:
  - req_l = move_cmd[2], req_r = move_cmd[3], any = req_l | req_r.
  - On an edge where any = 1 and the previous sampled any = 0: blink counter <= 0, phase <= 1.
  - Otherwise, while any = 1: at blink count BLINK_DIV-1 the counter wraps and phase toggles.
  - While any = 0: counter and phase are held at 0.
  - led_left <= req_l & phase_next and led_right <= req_r & phase_next. A new request therefore lights its LED at the first sampling edge.
  - When a request drops, its LED is 0 at that edge.
  - Both requests set: both LEDs blink in sync (hazard).
  - A switch between left and right without an intervening any = 0 does not restart the phase.
  - state == power_off forces LEDs to 0 and clears counter and phase.
- Display scan:
  - The scan counter counts 0..SCAN_DIV-1. On wrap, digit index advances 0 -> 1 -> 2 -> 3 -> 0.
  - seg_en is the one-hot of the digit index. seg_out is the 7-segment decode of the selected odo_bcd digit. Both update on the same edge.
  - Leading zeros are displayed.
  - state == power_off: seg_en = 0000 and seg_out = 0000000. The scan counter keeps running.
  - Leaving power_off resumes scanning from the current index with no glitch cycle.
- Decode, as {g..a}: 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110, 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111.
- Reset mid-operation: all state returns to reset values immediately. There is no partial update on the following edge.

Test Plan (TICK_DIV=10, BLINK_DIV=4, SCAN_DIV=3):
- Reset, then state=0100, move_cmd=0001 for 35 cycles -> odo_bcd = 0x0003, with increments exactly every 10 cycles. Then move_cmd=0000 for 5 cycles and 0001 for 9 cycles -> odo_bcd is still 0x0003 (prescaler was reset).
- Preload near the wrap by running moving to 0x0009, then 0x0099, then 0x9999 -> carries give 0x0010, 0x0100, and 0x0000 after 9999. Assert clr_odo in the same cycle as a tick -> odo_bcd = 0x0000.
- state=0010, move_cmd=0100 from cycle 0 -> led_left = 1 on cycles 0-3, 0 on 4-7, 1 on 8-11; led_right stays 0. Drop the request mid-phase -> led_left = 0 on that edge.
- move_cmd=1100 -> both LEDs toggle identically. Then state=1000 -> both LEDs 0 on the next edge and the odometer is unchanged.
- odo_bcd=0x1234 and state=0001 -> seg_en cycles 0001, 0010, 0100, 1000 every 3 cycles with seg_out = 1100110, 1001111, 1011011, 0000110 respectively. Then state=1000 -> seg_en = 0000 and seg_out = 0. Then state=0001 -> scanning resumes.
- Assert rst low asynchronously mid-blink and mid-scan -> all outputs take their reset values before the next clk edge.
